// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared widths, constants, FSM encodings and FIFO entry type for the fetch stage.
package fetch_unit_pkg;
  localparam int ADR_WIDTH = 48;
  localparam int DAT_WIDTH = 64;
  localparam logic [ADR_WIDTH-1:0] ROM_BASE = 48'h8000_0000_0000;
  localparam logic [DAT_WIDTH-1:0] HALT_INSN = 64'hfe00_0000_0000_0000;
  localparam logic [1:0] FETCH_IDLE = 2'd0;
  localparam logic [1:0] FETCH_REQ = 2'd1;
  localparam logic [1:0] FETCH_GAP = 2'd2;
  typedef struct packed {
    logic [ADR_WIDTH-1:0] pc;
    logic [DAT_WIDTH-1:0] insn;
    logic fault;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_fifo.sv
// fetch_unit_fifo: synchronous instruction buffer with flush; head reads as zero when empty.
module fetch_unit_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  fetch_entry_t             i_din,
  output fetch_entry_t             o_dout,
  output logic                     o_valid,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t r_mem [DEPTH];
  logic [AW-1:0] r_rd, r_wr;
  logic [AW:0] r_count;
  logic w_push, w_pop;
  assign w_push = i_push && !i_flush;
  assign w_pop = i_pop && !i_flush && r_count != '0;
  always_ff @(posedge i_clk)
    if (!i_rst_n || i_flush) begin
      r_rd <= '0;
      r_wr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  always_ff @(posedge i_clk)
    if (w_push) r_mem[r_wr] <= i_din;
  assign o_valid = r_count != '0;
  assign o_dout = o_valid ? r_mem[r_rd] : '0;
  assign o_count = r_count;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: Wishbone read master fetching 64-bit instructions at pc into a small FIFO for decode.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [ADR_WIDTH-1:0] RESET_PC = ROM_BASE,
  parameter int FIFO_DEPTH = 2,
  parameter int INSN_BYTES = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  output logic [ADR_WIDTH-1:0] fetch_adr_o,
  input  logic [DAT_WIDTH-1:0] fetch_dat_i,
  output logic [DAT_WIDTH-1:0] fetch_dat_o,
  output logic                 fetch_we_o,
  output logic                 fetch_stb_o,
  output logic                 fetch_cyc_o,
  input  logic                 fetch_ack_i,
  input  logic                 fetch_err_i,
  output logic                 insn_valid_o,
  input  logic                 insn_ready_i,
  output logic [DAT_WIDTH-1:0] insn_o,
  output logic [ADR_WIDTH-1:0] insn_pc_o,
  output logic                 insn_fault_o,
  input  logic                 redirect_i,
  input  logic [ADR_WIDTH-1:0] redirect_pc_i
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [1:0] r_state;
  logic [ADR_WIDTH-1:0] r_pc, r_adr;
  logic r_lock, r_discard;
  logic [CW-1:0] w_count;
  logic w_done, w_keep, w_issue, w_valid;
  fetch_entry_t w_din, w_head;
  assign w_done = r_state == FETCH_REQ && (fetch_ack_i || fetch_err_i);
  assign w_keep = w_done && !r_discard && !redirect_i;
  assign w_issue = w_count < CW'(FIFO_DEPTH) && !r_lock && !redirect_i;
  assign w_din = '{pc: r_pc, insn: fetch_err_i ? HALT_INSN : fetch_dat_i, fault: fetch_err_i};
  // The bus address is latched at issue so a redirect can move pc without disturbing the open cycle.
  always_ff @(posedge clk_i)
    if (!rst_i) begin
      r_state <= FETCH_IDLE;
      r_pc <= RESET_PC;
      r_adr <= RESET_PC;
      r_lock <= 1'b0;
      r_discard <= 1'b0;
    end else begin
      r_state <= r_state == FETCH_REQ ? (w_done ? FETCH_GAP : FETCH_REQ) : (w_issue ? FETCH_REQ : FETCH_IDLE);
      r_pc <= redirect_i ? {redirect_pc_i[ADR_WIDTH-1:3], 3'b000} :
              (w_keep && !fetch_err_i) ? r_pc + ADR_WIDTH'(INSN_BYTES) : r_pc;
      r_lock <= !redirect_i && (r_lock || (w_keep && fetch_err_i));
      r_discard <= w_done ? 1'b0 : (redirect_i && r_state == FETCH_REQ) ? 1'b1 : r_discard;
      if (r_state != FETCH_REQ && w_issue) r_adr <= r_pc;
    end
  fetch_unit_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk(clk_i),
    .i_rst_n(rst_i),
    .i_push(w_keep),
    .i_pop(w_valid && insn_ready_i),
    .i_flush(redirect_i),
    .i_din(w_din),
    .o_dout(w_head),
    .o_valid(w_valid),
    .o_count(w_count)
  );
  assign fetch_adr_o = r_adr;
  assign fetch_dat_o = '0;
  assign fetch_we_o = 1'b0;
  assign fetch_stb_o = r_state == FETCH_REQ;
  assign fetch_cyc_o = fetch_stb_o;
  assign insn_valid_o = w_valid;
  assign insn_o = w_head.insn;
  assign insn_pc_o = w_head.pc;
  assign insn_fault_o = w_head.fault;
endmodule
